// File: rtl/serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: controller states, slice width
// and the nibble-index width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int NIBBLE_W = 4;

    // Width of a counter that must reach nibbles-1; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/add4_slice.sv
// Purely combinational 4-bit adder with carry in and carry out; the only adder
// in the nibble-serial datapath.
module add4_slice
    import serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                c_o
);

    assign {c_o, s_o} = (NIBBLE_W + 1)'(a_i) + (NIBBLE_W + 1)'(b_i) + (NIBBLE_W + 1)'(c_i);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice, LSB nibble first, with valid/ready
// on both sides. Define SERIAL_ADD_SUB_EN to add the in_sub port (A - B support).
module nibble_serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int                   NIBBLES  = WIDTH / NIBBLE_W;
    localparam int                   IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [WIDTH-1:0]     NIB_MASK = WIDTH'({NIBBLE_W{1'b1}});

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               cout_q;
    logic               ovf_q;
    logic [IDX_W-1:0]   idx_q;

    logic [WIDTH-1:0]    b_eff;
    logic                cin_eff;
    logic [IDX_W+1:0]    shamt;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                c_nib;
    logic [WIDTH-1:0]    sum_d;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is A + ~B + 1; in_cin has no meaning in that mode.
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ? 1'b1  : in_cin;
`else
    assign b_eff   = in_b;
    assign cin_eff = in_cin;
`endif

    // Bit offset of the current nibble (index * 4).
    assign shamt = {idx_q, 2'b00};
    assign a_nib = NIBBLE_W'(a_q >> shamt);
    assign b_nib = NIBBLE_W'(b_q >> shamt);

    add4_slice u_slice (
        .a_i (a_nib),
        .b_i (b_nib),
        .c_i (carry_q),
        .s_o (s_nib),
        .c_o (c_nib)
    );

    assign sum_d = (sum_q & ~(NIB_MASK << shamt)) | (WIDTH'(s_nib) << shamt);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= c_nib;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= c_nib;
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (s_nib[NIBBLE_W-1] != a_q[WIDTH-1]);
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: table vectors, random ops against a
// reference model, backpressure, mid-run reset, and a WIDTH=4 instance.
module tb_nibble_serial_adder;

    localparam int W  = 16;
    localparam int NB = W / 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, out_ovf, busy;
    logic [W-1:0] out_sum;

    logic       v4_in_valid, v4_in_ready, v4_in_cin, v4_in_sub;
    logic [3:0] v4_in_a, v4_in_b, v4_out_sum;
    logic       v4_out_valid, v4_out_ready, v4_out_cout, v4_out_ovf, v4_busy;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef SERIAL_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4_in_valid),
        .in_ready  (v4_in_ready),
        .in_a      (v4_in_a),
        .in_b      (v4_in_b),
        .in_cin    (v4_in_cin),
`ifdef SERIAL_ADD_SUB_EN
        .in_sub    (v4_in_sub),
`endif
        .out_valid (v4_out_valid),
        .out_ready (v4_out_ready),
        .out_sum   (v4_out_sum),
        .out_cout  (v4_out_cout),
        .out_ovf   (v4_out_ovf),
        .busy      (v4_busy)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        exp_t         e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         r;
        logic [W-1:0] bp;
        logic         c0;
        bp = sub ? ~b : b;
        c0 = sub ? 1'b1 : cin;
        {r.cout, r.sum} = (W + 1)'(a) + (W + 1)'(bp) + (W + 1)'(c0);
        r.ovf = (a[W-1] == bp[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    // Present operands, accept on the next edge, then scramble the inputs.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, input exp_t e, input bit push);
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        check("in_ready before accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom); in_sub = 1'($urandom);
        if (push) sb.push_back(e);
    endtask

    task automatic wait_valid(input int exp_lat, input string tag);
        int   cyc = 0;
        exp_t e;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " scoreboard has entry"}, (sb.size() != 0), 1);
        if (out_valid && sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, " sum"},  out_sum,  e.sum);
            check({tag, " cout"}, out_cout, e.cout);
            check({tag, " ovf"},  out_ovf,  e.ovf);
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " in_ready after handshake"}, in_ready, 1);
        check({tag, " out_valid after handshake"}, out_valid, 0);
    endtask

    initial begin
        exp_t e;
        bit   seen;

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        v4_in_valid = 1'b0; v4_in_a = '0; v4_in_b = '0; v4_in_cin = 1'b0; v4_in_sub = 1'b0;
        v4_out_ready = 1'b0;

        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, '{16'h0001, 1'b0, 1'b0}});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0}});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}});
        vecs.push_back('{16'h0009, 16'h0003, 1'b1, 1'b1, '{16'h0006, 1'b1, 1'b0}});
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_sum",   out_sum,   0);
        check("reset out_cout",  out_cout,  0);
        check("reset out_ovf",   out_ovf,   0);
        check("reset busy",      busy,      0);
        check("reset in_ready",  in_ready,  1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].e, 1'b1);
            wait_valid(NB, $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] a, b;
            logic         c, s;
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            drive_op(a, b, c, s, model(a, b, c, s), 1'b1);
            wait_valid(NB, $sformatf("rnd%0d", i));
            release_result($sformatf("rnd%0d", i));
        end

        // Backpressure: result held while a new request waits.
        drive_op(16'h0F0F, 16'h1111, 1'b1, 1'b0, '{16'h2021, 1'b0, 1'b0}, 1'b1);
        wait_valid(NB, "bp");
        @(negedge clk);
        in_a = 16'h0102; in_b = 16'h0304; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d out_valid", k), out_valid, 1);
            check($sformatf("bp hold%0d in_ready", k),  in_ready,  0);
            check($sformatf("bp hold%0d out_sum", k),   out_sum,   16'h2021);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp idle in_ready", in_ready, 1);
        check("bp idle busy",     busy,     0);
        sb.push_back('{16'h0406, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp next accepted busy", busy, 1);
        wait_valid(NB, "bp next");
        release_result("bp next");

        // Reset after two RUN cycles discards the partial result.
        drive_op(16'hAAAA, 16'h5555, 1'b0, 1'b0, '{16'hFFFF, 1'b0, 1'b0}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 0);
        check("midrst out_sum",   out_sum,   0);
        check("midrst out_cout",  out_cout,  0);
        check("midrst out_ovf",   out_ovf,   0);
        check("midrst busy",      busy,      0);
        check("midrst in_ready",  in_ready,  1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst no stale out_valid", seen, 0);
        drive_op(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0}, 1'b1);
        wait_valid(NB, "post rst");
        release_result("post rst");

        // WIDTH=4 instance: single RUN cycle.
        for (int i = 0; i < 2; i++) begin
            logic [3:0] ea, eb, es;
            logic       ec, eo;
            ea = (i == 0) ? 4'hF : 4'h7;
            eb = 4'h1;
            es = (i == 0) ? 4'h0 : 4'h8;
            ec = (i == 0);
            eo = (i == 1);
            @(negedge clk);
            v4_in_a = ea; v4_in_b = eb; v4_in_cin = 1'b0; v4_in_sub = 1'b0; v4_in_valid = 1'b1;
            check($sformatf("w4 op%0d in_ready", i), v4_in_ready, 1);
            @(posedge clk);
            #1;
            v4_in_valid = 1'b0;
            check($sformatf("w4 op%0d not yet valid", i), v4_out_valid, 0);
            @(posedge clk);
            #1;
            check($sformatf("w4 op%0d out_valid", i), v4_out_valid, 1);
            check($sformatf("w4 op%0d sum", i),       v4_out_sum,   es);
            check($sformatf("w4 op%0d cout", i),      v4_out_cout,  ec);
            check($sformatf("w4 op%0d ovf", i),       v4_out_ovf,   eo);
            @(negedge clk);
            v4_out_ready = 1'b1;
            @(posedge clk);
            #1;
            v4_out_ready = 1'b0;
            check($sformatf("w4 op%0d back to idle", i), v4_in_ready, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
